// File: rtl/pts_tx_framer.sv
// Parallel-to-serial transmit framer.
// Frame on serial_out: one start bit (0), NUM_BITS data bits, one stop bit (1).
// Every bit period is one shift_strobe; the line idles high.
//
//   state | meaning
//   IDLE  | line high, data_ready=1, waiting for data_valid
//   START | word latched, start bit (0) on the line until the next strobe
//   DATA  | data bits on the line, one per strobe, bit_cnt counts bits sent
//   STOP  | stop bit (1) on the line; the next strobe ends the frame
module pts_tx_framer #(
  parameter int NUM_BITS  = 4,
  parameter int SHIFT_MSB = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                data_valid,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                data_ready,
  input  logic                shift_strobe,
  output logic                serial_out,
  output logic                busy,
  output logic                tx_done
);

  localparam int CNT_W = $clog2(NUM_BITS) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                serial_q, serial_d;
  logic                done_q,  done_d;

  logic                head_bit;
  logic [NUM_BITS-1:0] shift_next;

  // The bit leaving the shift register next, and the register after it leaves.
  // Shifting toward the transmit end keeps the next bit always in one place.
  assign head_bit   = (SHIFT_MSB != 0) ? shift_q[NUM_BITS-1] : shift_q[0];
  assign shift_next = (SHIFT_MSB != 0) ? (shift_q << 1) : (shift_q >> 1);

  // Next-state, shift register, bit counter and line level.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        // A strobe on the acceptance edge is deliberately ignored so the
        // start bit always lasts a full strobe period.
        if (data_valid) begin
          shift_d  = parallel_in;
          cnt_d    = '0;
          serial_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (shift_strobe) begin
          serial_d = head_bit;
          shift_d  = shift_next;
          cnt_d    = CNT_W'(1);
          state_d  = DATA;
        end
      end
      DATA: begin
        if (shift_strobe) begin
          if (cnt_q == CNT_W'(NUM_BITS)) begin
            serial_d = 1'b1;
            cnt_d    = '0;
            state_d  = STOP;
          end else begin
            serial_d = head_bit;
            shift_d  = shift_next;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (shift_strobe) begin
          serial_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        serial_d = 1'b1;
        shift_d  = '0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns the line to idle at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign serial_out = serial_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_pts_tx_framer.sv
// Directed bench for pts_tx_framer: an MSB-first and an LSB-first instance
// share one stimulus so both bit orders are checked on every frame.
module tb_pts_tx_framer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       data_valid = 1'b0;
  logic [3:0] parallel_in = 4'd0;
  logic       shift_strobe = 1'b0;

  logic m_ready, m_serial, m_busy, m_done;
  logic l_ready, l_serial, l_busy, l_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pts_tx_framer #(.NUM_BITS(4), .SHIFT_MSB(1)) dut_msb (
    .clk(clk), .n_rst(n_rst), .data_valid(data_valid), .parallel_in(parallel_in),
    .data_ready(m_ready), .shift_strobe(shift_strobe), .serial_out(m_serial),
    .busy(m_busy), .tx_done(m_done)
  );

  pts_tx_framer #(.NUM_BITS(4), .SHIFT_MSB(0)) dut_lsb (
    .clk(clk), .n_rst(n_rst), .data_valid(data_valid), .parallel_in(parallel_in),
    .data_ready(l_ready), .shift_strobe(shift_strobe), .serial_out(l_serial),
    .busy(l_busy), .tx_done(l_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    data_valid = 1'b0;
    shift_strobe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) n_rst = 1'b1;
      step();
      total++;
      if ({m_serial, m_ready, m_busy, m_done} !== 4'b1100) begin
        bad++;
        $display("FAIL reset_msb cyc=%0d got ser/rdy/busy/done=%b want 1100", i,
                 {m_serial, m_ready, m_busy, m_done});
      end
      total++;
      if ({l_serial, l_ready, l_busy, l_done} !== 4'b1100) begin
        bad++;
        $display("FAIL reset_lsb cyc=%0d got ser/rdy/busy/done=%b want 1100", i,
                 {l_serial, l_ready, l_busy, l_done});
      end
    end
  endtask

  task automatic test_bit_order();
    logic [5:0] exp_m, exp_l;
    exp_m = 6'b110110;  // 1101 MSB first: 0,1,1,0,1,1
    exp_l = 6'b111010;  // 1101 LSB first: 0,1,0,1,1,1
    shift_strobe = 1'b1;
    data_valid = 1'b1;
    parallel_in = 4'b1101;
    step();
    data_valid = 1'b0;
    parallel_in = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (m_serial !== exp_m[i] || m_busy !== 1'b1 || m_done !== 1'b0) begin
        bad++;
        $display("FAIL order_msb bit=%0d got ser=%b busy=%b done=%b want ser=%b busy=1 done=0",
                 i, m_serial, m_busy, m_done, exp_m[i]);
      end
      total++;
      if (l_serial !== exp_l[i] || l_busy !== 1'b1 || l_done !== 1'b0) begin
        bad++;
        $display("FAIL order_lsb bit=%0d got ser=%b busy=%b done=%b want ser=%b busy=1 done=0",
                 i, l_serial, l_busy, l_done, exp_l[i]);
      end
      step();
    end
    total++;
    if ({m_done, m_ready, m_serial, l_done, l_ready, l_serial} !== 6'b111111) begin
      bad++;
      $display("FAIL order_done got m done/rdy/ser=%b l=%b want 111 111",
               {m_done, m_ready, m_serial}, {l_done, l_ready, l_serial});
    end
    step();
    total++;
    if (m_done !== 1'b0 || l_done !== 1'b0) begin
      bad++;
      $display("FAIL order_done_pulse got m=%b l=%b want 0 0", m_done, l_done);
    end
  endtask

  task automatic test_slow_strobe();
    logic [5:0] exp_m, exp_l;
    int s;
    exp_m = 6'b101000;  // 0010 MSB first: 0,0,0,1,0,1
    exp_l = 6'b100100;  // 0010 LSB first: 0,0,1,0,0,1
    shift_strobe = 1'b1;  // coincides with acceptance and must be ignored
    data_valid = 1'b1;
    parallel_in = 4'b0010;
    step();
    for (int k = 1; k <= 18; k++) begin
      s = (k - 1) / 3;
      total++;
      if (m_serial !== exp_m[s] || l_serial !== exp_l[s] || m_busy !== 1'b1 || l_busy !== 1'b1) begin
        bad++;
        $display("FAIL slow_bit cyc=%0d got ser m=%b l=%b busy m=%b l=%b want m=%b l=%b busy=1",
                 k - 1, m_serial, l_serial, m_busy, l_busy, exp_m[s], exp_l[s]);
      end
      shift_strobe = (k % 3 == 0);
      data_valid = (k >= 2 && k <= 16);
      parallel_in = (k >= 2) ? 4'b1111 : 4'b0010;
      step();
    end
    data_valid = 1'b0;
    total++;
    if (m_done !== 1'b1 || l_done !== 1'b1 || m_ready !== 1'b1 || l_ready !== 1'b1) begin
      bad++;
      $display("FAIL slow_done at 18 clks got done m=%b l=%b rdy m=%b l=%b want 1111",
               m_done, l_done, m_ready, l_ready);
    end
    shift_strobe = 1'b0;
    step();
    total++;
    if (m_done !== 1'b0 || m_ready !== 1'b1 || m_serial !== 1'b1) begin
      bad++;
      $display("FAIL slow_idle got done=%b rdy=%b ser=%b want 0 1 1", m_done, m_ready, m_serial);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0] exp_m, exp_l;
    exp_m = 6'b100010;  // 1000 MSB first: 0,1,0,0,0,1
    exp_l = 6'b110000;  // 1000 LSB first: 0,0,0,0,1,1
    shift_strobe = 1'b1;
    data_valid = 1'b1;
    parallel_in = 4'b1001;
    step();
    data_valid = 1'b0;
    step();
    step();
    total++;
    if (m_serial !== 1'b0 || l_serial !== 1'b0 || m_busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre got ser m=%b l=%b busy=%b want 0 0 1", m_serial, l_serial, m_busy);
    end
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if ({m_serial, m_busy, m_ready, m_done, l_serial, l_busy, l_ready, l_done} !== 8'b1010_1010) begin
      bad++;
      $display("FAIL rst_async got m ser/busy/rdy/done=%b l=%b want 1010 1010",
               {m_serial, m_busy, m_ready, m_done}, {l_serial, l_busy, l_ready, l_done});
    end
    step();
    #2;
    n_rst = 1'b1;
    data_valid = 1'b1;
    parallel_in = 4'b1000;
    step();
    data_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (m_serial !== exp_m[i] || l_serial !== exp_l[i] || m_done !== 1'b0 || l_done !== 1'b0) begin
        bad++;
        $display("FAIL rst_next bit=%0d got ser m=%b l=%b done m=%b l=%b want m=%b l=%b done=0",
                 i, m_serial, l_serial, m_done, l_done, exp_m[i], exp_l[i]);
      end
      step();
    end
    total++;
    if (m_done !== 1'b1 || l_done !== 1'b1) begin
      bad++;
      $display("FAIL rst_next_done got m=%b l=%b want 1 1", m_done, l_done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] a_m, a_l, b_m, b_l;
    a_m = 6'b101010;  // 1010 MSB first: 0,1,0,1,0,1
    a_l = 6'b110100;  // 1010 LSB first: 0,0,1,0,1,1
    b_m = 6'b111100;  // 0111 MSB first: 0,0,1,1,1,1
    b_l = 6'b101110;  // 0111 LSB first: 0,1,1,1,0,1
    shift_strobe = 1'b1;
    data_valid = 1'b1;
    parallel_in = 4'b1010;
    step();
    parallel_in = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (m_serial !== a_m[i] || l_serial !== a_l[i]) begin
        bad++;
        $display("FAIL b2b_a bit=%0d got ser m=%b l=%b want m=%b l=%b",
                 i, m_serial, l_serial, a_m[i], a_l[i]);
      end
      step();
    end
    total++;
    if (m_done !== 1'b1 || m_ready !== 1'b1 || l_done !== 1'b1 || l_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap got done m=%b l=%b rdy m=%b l=%b want 1111",
               m_done, l_done, m_ready, l_ready);
    end
    step();
    data_valid = 1'b0;
    total++;
    if (m_busy !== 1'b1 || l_busy !== 1'b1 || m_done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got busy m=%b l=%b done=%b want 1 1 0", m_busy, l_busy, m_done);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (m_serial !== b_m[i] || l_serial !== b_l[i]) begin
        bad++;
        $display("FAIL b2b_b bit=%0d got ser m=%b l=%b want m=%b l=%b",
                 i, m_serial, l_serial, b_m[i], b_l[i]);
      end
      step();
    end
    total++;
    if (m_done !== 1'b1 || l_done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_b_done got m=%b l=%b want 1 1", m_done, l_done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_slow_strobe();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
